// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_id_t;

  localparam int unsigned DEFAULT_MAX_WAIT = 32'd4;

  // Returns the port that is not p; used to pick the round-robin winner.
  function automatic port_id_t other_port(input port_id_t p);
    port_id_t r;
    if (p == PORT_CPU) begin
      r = PORT_AUX;
    end else begin
      r = PORT_CPU;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for the auxiliary port.
// Clear wins over increment; sat_o flags that the count reached MAX_WAIT.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE     = {{(WAIT_W-1){1'b0}}, 1'b1};

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WAIT_W{1'b0}};
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WAIT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port.
// Port 0 is the CPU datapath, port 1 the auxiliary master (loader/debug DMA).
// Default build: CPU fixed priority, port 1 forced to win after MAX_WAIT
// consecutive denied cycles. Defining DMEM_ARB_RR_EN switches contested
// cycles to round-robin via last_gnt and removes the starvation counter.
// Read data comes back one cycle after the grant and is steered to the
// port that issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [N-1:0] p0_addr,
  input  logic [N-1:0] p0_wdata,
  output logic         p0_gnt,
  output logic [N-1:0] p0_rdata,
  output logic         p0_rvalid,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [N-1:0] p1_addr,
  input  logic [N-1:0] p1_wdata,
  output logic         p1_gnt,
  output logic [N-1:0] p1_rdata,
  output logic         p1_rvalid,
  output logic         mem_we,
  output logic         mem_re,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  logic         gnt0_s;
  logic         gnt1_s;
  logic         mem_we_s;
  logic         mem_re_s;
  logic [N-1:0] mem_addr_s;
  logic [N-1:0] mem_wdata_s;

  logic         rd_pend_q;
  logic         rd_pend_d;
  port_id_t     rd_owner_q;
  port_id_t     rd_owner_d;

  logic         p0_rvalid_s;
  logic         p1_rvalid_s;
  logic [N-1:0] p0_rdata_s;
  logic [N-1:0] p1_rdata_s;

`ifdef DMEM_ARB_RR_EN
  port_id_t     last_gnt_q;
  port_id_t     last_gnt_d;
  port_id_t     rr_winner_s;

  assign rr_winner_s = other_port(last_gnt_q);
`else
  logic         sat_s;
  logic         wait_inc_s;
  logic         wait_clr_s;

  // Port 1 is denied while asking; any grant or idle cycle restarts the wait.
  assign wait_inc_s = p1_req & ~gnt1_s;
  assign wait_clr_s = gnt1_s | ~p1_req;

  arb_wait_counter #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (wait_inc_s),
    .clr_i (wait_clr_s),
    .sat_o (sat_s)
  );
`endif

  // Grant decision in the request cycle; nothing is granted while in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
      if (rr_winner_s == PORT_AUX) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
`else
      if (sat_s) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
`endif
    end else if (p0_req) begin
      gnt0_s = 1'b1;
    end else if (p1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Memory-side mux from the granted port; zero when nobody is granted.
  always_comb begin
    mem_addr_s  = {N{1'b0}};
    mem_wdata_s = {N{1'b0}};
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    if (gnt0_s) begin
      mem_addr_s  = p0_addr;
      mem_wdata_s = p0_wdata;
      mem_we_s    = p0_we;
      mem_re_s    = ~p0_we;
    end else if (gnt1_s) begin
      mem_addr_s  = p1_addr;
      mem_wdata_s = p1_wdata;
      mem_we_s    = p1_we;
      mem_re_s    = ~p1_we;
    end else begin
      mem_addr_s  = {N{1'b0}};
      mem_wdata_s = {N{1'b0}};
      mem_we_s    = 1'b0;
      mem_re_s    = 1'b0;
    end
  end

  // Remember whether a read was issued this cycle and which port owns it.
  always_comb begin
    rd_pend_d  = mem_re_s;
    rd_owner_d = rd_owner_q;
    if (gnt1_s && !p1_we) begin
      rd_owner_d = PORT_AUX;
    end else if (gnt0_s && !p0_we) begin
      rd_owner_d = PORT_CPU;
    end else begin
      rd_owner_d = rd_owner_q;
    end
  end

  // Outstanding-read tracking registers; reset drops any pending read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= PORT_CPU;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Next last_gnt: follows every grant, holds on idle cycles.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0_s) begin
      last_gnt_d = PORT_CPU;
    end else if (gnt1_s) begin
      last_gnt_d = PORT_AUX;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_q <= PORT_CPU;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Steer returning read data to its owner; the other port sees zeros.
  always_comb begin
    p0_rvalid_s = 1'b0;
    p1_rvalid_s = 1'b0;
    p0_rdata_s  = {N{1'b0}};
    p1_rdata_s  = {N{1'b0}};
    if (rd_pend_q && (rd_owner_q == PORT_CPU)) begin
      p0_rvalid_s = 1'b1;
      p0_rdata_s  = mem_rdata;
    end else if (rd_pend_q && (rd_owner_q == PORT_AUX)) begin
      p1_rvalid_s = 1'b1;
      p1_rdata_s  = mem_rdata;
    end else begin
      p0_rvalid_s = 1'b0;
      p1_rvalid_s = 1'b0;
    end
  end

  assign p0_gnt    = gnt0_s;
  assign p1_gnt    = gnt1_s;
  assign mem_we    = mem_we_s;
  assign mem_re    = mem_re_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign p0_rvalid = p0_rvalid_s;
  assign p1_rvalid = p1_rvalid_s;
  assign p0_rdata  = p0_rdata_s;
  assign p1_rdata  = p1_rdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant checks inline per scenario,
// read returns checked against a scoreboard of expected (owner, data).
module tb_dmem_arbiter;

  localparam int N    = 64;
  localparam int MAXW = 4;

  typedef struct {
    logic          port;
    logic [N-1:0]  data;
    int            due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [N-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [N-1:0] p0_rdata, p1_rdata;
  logic         mem_we, mem_re;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;

  logic [N-1:0] mem_arr [0:31];
  exp_t         sb_q [$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  dmem_arbiter #(.N(N), .MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time scoreboard entries.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] init_val(input int idx);
    logic [N-1:0] v;
    case (idx)
      1:       v = 64'h0000_0000_0000_DEAD;
      2:       v = 64'h0000_0000_0000_0011;
      3:       v = 64'h0000_0000_0000_0022;
      default: v = 64'hA5A5_0000_0000_0000 | 64'(idx);
    endcase
    return v;
  endfunction

  // Memory model: one-cycle read latency, garbage on the bus when idle.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= init_val(i);
      mem_rdata <= 64'h0;
    end else begin
      if (mem_we) mem_arr[mem_addr[7:3]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem_arr[mem_addr[7:3]];
      else        mem_rdata <= 64'hC0FF_EE00_0BAD_F00D;
    end
  end

  // Read-return monitor: compares every cycle against the scoreboard.
  logic         m_e0, m_e1;
  logic [N-1:0] m_d0, m_d1;
  exp_t         m_it;
  initial begin
    forever begin
      @(negedge clk);
      m_e0 = 1'b0; m_e1 = 1'b0; m_d0 = 64'h0; m_d1 = 64'h0;
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        n_vec++; n_err++;
        $display("FAIL rd_return_missed: entry due %0d still queued at cycle %0d", sb_q[0].due, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        m_it = sb_q.pop_front();
        if (m_it.port) begin m_e1 = 1'b1; m_d1 = m_it.data; end
        else begin m_e0 = 1'b1; m_d0 = m_it.data; end
      end
      n_vec++;
      if (p0_rvalid !== m_e0 || p0_rdata !== m_d0) begin
        n_err++;
        $display("FAIL p0_return @%0d: got v=%b d=%0h expected v=%b d=%0h", cyc, p0_rvalid, p0_rdata, m_e0, m_d0);
      end
      n_vec++;
      if (p1_rvalid !== m_e1 || p1_rdata !== m_d1) begin
        n_err++;
        $display("FAIL p1_return @%0d: got v=%b d=%0h expected v=%b d=%0h", cyc, p1_rvalid, p1_rdata, m_e1, m_d1);
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [N-1:0] a0, input logic [N-1:0] d0,
                       input logic r1, input logic w1, input logic [N-1:0] a1, input logic [N-1:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic port, input logic [N-1:0] data);
    exp_t e;
    e.port = port; e.data = data; e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic exp1;
    reset = 1'b0;
    drive(1'b1, 1'b1, 64'h40, 64'h1, 1'b1, 1'b1, 64'h48, 64'h2);
    next_cycle(); next_cycle();
    @(negedge clk);
    n_vec++;
    if ({p0_gnt, p1_gnt, mem_we, mem_re} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: got gnt0/gnt1/we/re=%b expected 0000", {p0_gnt, p1_gnt, mem_we, mem_re});
    end
    n_vec++;
    if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      n_err++;
      $display("FAIL reset_membus: got addr=%0h wdata=%0h expected 0", mem_addr, mem_wdata);
    end
    next_cycle();
    reset = 1'b1;
`ifdef DMEM_ARB_RR_EN
    exp1 = 1'b1;
`else
    exp1 = 1'b0;
`endif
    @(negedge clk);
    n_vec++;
    if (p0_gnt !== ~exp1 || p1_gnt !== exp1) begin
      n_err++;
      $display("FAIL reset_release: got gnt0=%b gnt1=%b expected gnt0=%b gnt1=%b", p0_gnt, p1_gnt, ~exp1, exp1);
    end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    n_vec++;
    if ({p0_gnt, p1_gnt, mem_we, mem_re} !== 4'b0000 || mem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL idle: got gnt0/gnt1/we/re=%b addr=%0h expected 0000 0", {p0_gnt, p1_gnt, mem_we, mem_re}, mem_addr);
    end
    next_cycle();
  endtask

  task automatic test_cpu_read();
    drive(1'b1, 1'b0, 64'h8, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    push_read(1'b0, 64'hDEAD);
    @(negedge clk);
    n_vec++;
    if (p0_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h8) begin
      n_err++;
      $display("FAIL cpu_read_issue: got gnt=%b re=%b we=%b addr=%0h expected 1 1 0 8", p0_gnt, mem_re, mem_we, mem_addr);
    end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    n_vec++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 64'hDEAD || p1_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read_return: got v0=%b d0=%0h v1=%b expected 1 dead 0", p0_rvalid, p0_rdata, p1_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp1;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 64'h40, 64'h40, 1'b1, 1'b1, 64'h48, 64'h48);
      exp1 = (i == MAXW + 1);
      @(negedge clk);
      n_vec++;
      if (p0_gnt !== ~exp1 || p1_gnt !== exp1 || mem_addr !== (exp1 ? 64'h48 : 64'h40)) begin
        n_err++;
        $display("FAIL starve_c%0d: got gnt0=%b gnt1=%b addr=%0h expected gnt0=%b gnt1=%b", i, p0_gnt, p1_gnt, mem_addr, ~exp1, exp1);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    next_cycle();
  endtask

  task automatic test_withdraw();
    logic r1, exp1;
    for (int i = 0; i < 9; i++) begin
      r1 = (i != 3);
      exp1 = (i == 8);
      drive(1'b1, 1'b1, 64'h40, 64'h40, r1, 1'b1, 64'h48, 64'h48);
      @(negedge clk);
      n_vec++;
      if (p0_gnt !== ~exp1 || p1_gnt !== exp1) begin
        n_err++;
        $display("FAIL withdraw_c%0d: got gnt0=%b gnt1=%b expected gnt0=%b gnt1=%b", i, p0_gnt, p1_gnt, ~exp1, exp1);
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    next_cycle();
  endtask

  task automatic test_interleave();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0);
    push_read(1'b1, 64'h11);
    @(negedge clk);
    n_vec++;
    if (p1_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 64'h10) begin
      n_err++;
      $display("FAIL ilv_p1_issue: got gnt1=%b re=%b addr=%0h expected 1 1 10", p1_gnt, mem_re, mem_addr);
    end
    next_cycle();
    drive(1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    push_read(1'b0, 64'h22);
    @(negedge clk);
    n_vec++;
    if (p0_gnt !== 1'b1 || mem_addr !== 64'h18 || p1_rdata !== 64'h11) begin
      n_err++;
      $display("FAIL ilv_p0_issue: got gnt0=%b addr=%0h p1_rdata=%0h expected 1 18 11", p0_gnt, mem_addr, p1_rdata);
    end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    n_vec++;
    if (p0_rdata !== 64'h22 || p1_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ilv_p0_return: got p0_rdata=%0h p1_rvalid=%b expected 22 0", p0_rdata, p1_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h20, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    n_vec++;
    if (p1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 64'h20 || mem_wdata !== 64'h1234_5678_9ABC_DEF0) begin
      n_err++;
      $display("FAIL aux_write: got gnt1=%b we=%b re=%b addr=%0h wdata=%0h", p1_gnt, mem_we, mem_re, mem_addr, mem_wdata);
    end
    next_cycle();
    drive(1'b1, 1'b0, 64'h20, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    push_read(1'b0, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    n_vec++;
    if (p1_rvalid !== 1'b0 || mem_wdata !== 64'h0) begin
      n_err++;
      $display("FAIL write_no_rvalid: got p1_rvalid=%b wdata=%0h expected 0 0", p1_rvalid, mem_wdata);
    end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 64'h8, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    push_read(1'b0, 64'hDEAD);
    @(negedge clk);
    n_vec++;
    if (p0_gnt !== 1'b1 || mem_re !== 1'b1) begin
      n_err++;
      $display("FAIL midrd_issue: got gnt0=%b re=%b expected 1 1", p0_gnt, mem_re);
    end
    next_cycle();
    reset = 1'b0;
    sb_q.delete();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    n_vec++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 64'h0) begin
      n_err++;
      $display("FAIL midrd_in_reset: got v=%b d=%0h expected 0 0", p0_rvalid, p0_rdata);
    end
    next_cycle(); next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midrd_after_release: got v0=%b v1=%b expected 0 0", p0_rvalid, p1_rvalid);
    end
    next_cycle(); next_cycle();
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_rr();
    logic last, exp1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 64'h40, 64'h40, 1'b1, 1'b1, 64'h48, 64'h48);
      exp1 = ~last;
      @(negedge clk);
      n_vec++;
      if (p0_gnt !== ~exp1 || p1_gnt !== exp1) begin
        n_err++;
        $display("FAIL rr_c%0d: got gnt0=%b gnt1=%b expected gnt0=%b gnt1=%b", i, p0_gnt, p1_gnt, ~exp1, exp1);
      end
      last = exp1;
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
`ifdef DMEM_ARB_RR_EN
    test_rr();
`else
    test_starvation();
    test_withdraw();
`endif
    test_interleave();
    test_write_read();
    test_reset_mid_read();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
